// File: rtl/im_loader_pkg.sv
// Shared types and widths for the boot-time instruction-memory loader.
// Imported by the word packer and the loader top.
package im_loader_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/im_word_packer.sv
// Assembles four stream bytes into one big-endian instruction word.
// The fourth byte is passed straight through so the word is ready on its handshake.
module im_word_packer
    import im_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [BYTE_W-1:0]  i_data,
    output logic               o_word_ready,
    output logic [INSTR_W-1:0] o_word
);

    logic [1:0]                r_cnt;
    logic [INSTR_W-BYTE_W-1:0] r_shift;
    logic [4:0]                w_lsb;

    // Byte k lands at bits [31-8k -: 8]; only the upper three are stored.
    assign w_lsb        = 5'd16 - {r_cnt, 3'b000};
    assign o_word_ready = i_accept && (r_cnt == 2'd3);
    assign o_word       = {r_shift, i_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_accept && (r_cnt != 2'd3)) begin
            r_shift[w_lsb +: BYTE_W] <= i_data;
            r_cnt                    <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core
// in reset until a complete image has been written.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               s_valid,
    input  logic [BYTE_W-1:0]  s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               im_we,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               cpu_rst,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    word_count
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    state_t               r_state;
    logic                 r_last;
    logic                 w_hs;
    logic                 w_restart;
    logic                 w_clear;
    logic                 w_word_ready;
    logic [INSTR_W-1:0]   w_word;

    assign s_ready   = (r_state == ST_RECV);
    assign w_hs      = s_valid && s_ready;
    assign w_restart = start && ((r_state == ST_IDLE) ||
                                 (r_state == ST_DONE) ||
                                 (r_state == ST_ERR));
    assign w_clear   = w_restart || (r_state == ST_WRITE);

    im_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_accept     (w_hs),
        .i_data       (s_data),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            im_we   <= 1'b0;
            cpu_rst <= (r_state != ST_DONE);
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_state    <= ST_RECV;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                    end
                end
                ST_RECV: begin
                    if (w_hs && w_word_ready) begin
                        if (word_count == MAX_CNT) begin
                            r_state <= ST_ERR;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state  <= ST_WRITE;
                            im_we    <= 1'b1;
                            im_addr  <= word_count[ADDR_W-1:0];
                            im_wdata <= w_word;
                            r_last   <= s_last;
                        end
                    end else if (w_hs && s_last) begin
                        // Image ended mid-word.
                        r_state <= ST_ERR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    word_count <= word_count + 1'b1;
                    if (r_last) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= ST_RECV;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
